// File: rtl/snooper_cmd_pkg.sv
// Shared command/reply byte codes and controller state encoding for the snooper
// command path.
package snooper_cmd_pkg;

    localparam logic [7:0] CMD_RECORD  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_TRIGGER = 8'h74;  // 't'
    localparam logic [7:0] CMD_DUMP    = 8'h64;  // 'd'
    localparam logic [7:0] CMD_ABORT   = 8'h78;  // 'x'

    localparam logic [7:0] RPL_RECORD  = 8'h52;  // 'R'
    localparam logic [7:0] RPL_UNKNOWN = 8'h3F;  // '?'

    localparam logic [7:0] CHR_SPACE   = 8'h20;
    localparam logic [7:0] CHR_CR      = 8'h0D;
    localparam logic [7:0] CHR_LF      = 8'h0A;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REC_WAIT  = 3'd1,
        DUMP_LOAD = 3'd2,
        DUMP_HEX  = 3'd3,
        DUMP_SEP  = 3'd4,
        DUMP_NEXT = 3'd5,
        DUMP_TERM = 3'd6,
        REPLY     = 3'd7
    } state_t;

endpackage

// File: rtl/hex_ascii_encoder.sv
// Combinational nibble to upper-case ASCII hex digit.
module hex_ascii_encoder (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        if (nibble < 4'd10) begin
            ascii = 8'h30 + {4'd0, nibble};
        end else begin
            ascii = 8'h37 + {4'd0, nibble};
        end
    end

endmodule

// File: rtl/snooper_command_controller.sv
// Byte-command front end for the capture snooper: arms/triggers recording and
// streams captured words out as ASCII hex over the usart.
//
// state     | meaning
// IDLE      | waiting for a command byte
// REC_WAIT  | capture armed, waiting for record_end
// DUMP_LOAD | one-cycle settle after dump_start/dump_next, then latch word or finish
// DUMP_HEX  | sending the hex digits of the latched word, MS nibble first
// DUMP_SEP  | sending the space after a word
// DUMP_NEXT | pulsing dump_next and bumping the word counter
// DUMP_TERM | sending CR then LF (normal end or abort)
// REPLY     | sending a single reply byte
module snooper_command_controller
    import snooper_cmd_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 128
) (
    input  logic                comm_clock,
    input  logic                reset_n,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic                record_start,
    output logic                record_trigger,
    input  logic                record_end,
    output logic                dump_start,
    output logic                dump_next,
    input  logic                dump_end,
    input  logic [BITWIDTH-1:0] data_in,
    output logic                busy
);

    localparam int NIBBLES = BITWIDTH / 4;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int DIG_W   = $clog2(NIBBLES + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [BITWIDTH-1:0] shift_q, shift_d;
    logic [DIG_W-1:0]    digit_cnt_q, digit_cnt_d;
    logic                term_lf_q, term_lf_d;
    logic                load_wait_q, load_wait_d;
    logic [7:0]          reply_q, reply_d;
    logic                tx_gap_q;
    logic [7:0]          tx_data_d, hex_char;
    logic                tx_start_d, record_start_d, record_trigger_d;
    logic                dump_start_d, dump_next_d;
    logic                can_send, abort_req;

    hex_ascii_encoder u_hex (
        .nibble (shift_q[BITWIDTH-1 -: 4]),
        .ascii  (hex_char)
    );

    // A byte may only go out once the previous strobe is at least a cycle old
    // and the transmitter has had the chance to raise tx_busy.
    assign can_send  = !tx_busy && !tx_start && !tx_gap_q;
    assign abort_req = rx_valid && (rx_data == CMD_ABORT);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d          = state_q;
        word_cnt_d       = word_cnt_q;
        shift_d          = shift_q;
        digit_cnt_d      = digit_cnt_q;
        term_lf_d        = term_lf_q;
        load_wait_d      = load_wait_q;
        reply_d          = reply_q;
        tx_data_d        = tx_data;
        tx_start_d       = 1'b0;
        record_start_d   = 1'b0;
        record_trigger_d = 1'b0;
        dump_start_d     = 1'b0;
        dump_next_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CMD_RECORD: begin
                            record_start_d = 1'b1;
                            state_d        = REC_WAIT;
                        end
                        CMD_TRIGGER: record_trigger_d = 1'b1;
                        CMD_DUMP: begin
                            dump_start_d = 1'b1;
                            word_cnt_d   = '0;
                            load_wait_d  = 1'b1;
                            state_d      = DUMP_LOAD;
                        end
                        CMD_ABORT: ;
                        default: begin
                            reply_d = RPL_UNKNOWN;
                            state_d = REPLY;
                        end
                    endcase
                end
            end
            REC_WAIT: begin
                if (record_end) begin
                    reply_d = RPL_RECORD;
                    state_d = REPLY;
                end else if (rx_valid && rx_data == CMD_TRIGGER) begin
                    record_trigger_d = 1'b1;
                end else if (abort_req) begin
                    term_lf_d = 1'b0;
                    state_d   = DUMP_TERM;
                end
            end
            DUMP_LOAD: begin
                if (abort_req) begin
                    term_lf_d = 1'b0;
                    state_d   = DUMP_TERM;
                end else if (load_wait_q) begin
                    load_wait_d = 1'b0;
                end else if (dump_end || word_cnt_q == CNT_W'(DEPTH)) begin
                    term_lf_d = 1'b0;
                    state_d   = DUMP_TERM;
                end else begin
                    shift_d     = data_in;
                    digit_cnt_d = DIG_W'(NIBBLES);
                    state_d     = DUMP_HEX;
                end
            end
            DUMP_HEX: begin
                if (abort_req) begin
                    term_lf_d = 1'b0;
                    state_d   = DUMP_TERM;
                end else if (can_send) begin
                    tx_start_d  = 1'b1;
                    tx_data_d   = hex_char;
                    shift_d     = {shift_q[BITWIDTH-5:0], 4'h0};
                    digit_cnt_d = digit_cnt_q - 1'b1;
                    if (digit_cnt_q == DIG_W'(1)) begin
                        state_d = DUMP_SEP;
                    end
                end
            end
            DUMP_SEP: begin
                if (abort_req) begin
                    term_lf_d = 1'b0;
                    state_d   = DUMP_TERM;
                end else if (can_send) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = CHR_SPACE;
                    state_d    = DUMP_NEXT;
                end
            end
            DUMP_NEXT: begin
                if (abort_req) begin
                    term_lf_d = 1'b0;
                    state_d   = DUMP_TERM;
                end else begin
                    dump_next_d = 1'b1;
                    if (word_cnt_q != CNT_W'(DEPTH)) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                    load_wait_d = 1'b1;
                    state_d     = DUMP_LOAD;
                end
            end
            DUMP_TERM: begin
                if (can_send) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = term_lf_q ? CHR_LF : CHR_CR;
                    if (term_lf_q) begin
                        state_d = IDLE;
                    end else begin
                        term_lf_d = 1'b1;
                    end
                end
            end
            REPLY: begin
                // An abort drops a reply byte that has not gone out yet.
                if (abort_req) begin
                    term_lf_d = 1'b0;
                    state_d   = DUMP_TERM;
                end else if (can_send) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = reply_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            word_cnt_q     <= '0;
            shift_q        <= '0;
            digit_cnt_q    <= '0;
            term_lf_q      <= 1'b0;
            load_wait_q    <= 1'b0;
            reply_q        <= 8'h00;
            tx_gap_q       <= 1'b0;
            tx_data        <= 8'h00;
            tx_start       <= 1'b0;
            record_start   <= 1'b0;
            record_trigger <= 1'b0;
            dump_start     <= 1'b0;
            dump_next      <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_cnt_q     <= word_cnt_d;
            shift_q        <= shift_d;
            digit_cnt_q    <= digit_cnt_d;
            term_lf_q      <= term_lf_d;
            load_wait_q    <= load_wait_d;
            reply_q        <= reply_d;
            tx_gap_q       <= tx_start;
            tx_data        <= tx_data_d;
            tx_start       <= tx_start_d;
            record_start   <= record_start_d;
            record_trigger <= record_trigger_d;
            dump_start     <= dump_start_d;
            dump_next      <= dump_next_d;
        end
    end

endmodule

// File: tb/tb_snooper_command_controller.sv
// Self-checking bench for snooper_command_controller: usart and snooper models
// plus a byte-stream reference built from the command rules.
module tb_snooper_command_controller;

    localparam int DEPTH_TB = 4;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic        comm_clock = 1'b0;
    logic        reset_n    = 1'b0;
    logic [7:0]  rx_data    = 8'h00;
    logic        rx_valid   = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy    = 1'b0;
    logic        record_start;
    logic        record_trigger;
    logic        record_end = 1'b0;
    logic        dump_start;
    logic        dump_next;
    logic        dump_end   = 1'b1;
    logic [31:0] data_in    = 32'h0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    byte_q_t    tx_q;
    word_q_t    sn_words;
    int         sn_valid = 0;
    int         sn_ptr = 0;
    int         busy_len = 0;
    int         busy_cnt = 0;
    int         cyc = 0;
    int         last_start_cyc = -100;
    int         n_rec = 0, n_trig = 0, n_dstart = 0, n_dnext = 0;
    int         viol_busy = 0, viol_gap = 0, viol_stab = 0;
    logic [7:0] last_tx = 8'h00;

    snooper_command_controller #(.BITWIDTH(32), .DEPTH(DEPTH_TB)) dut (
        .comm_clock     (comm_clock),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .tx_data        (tx_data),
        .tx_start       (tx_start),
        .tx_busy        (tx_busy),
        .record_start   (record_start),
        .record_trigger (record_trigger),
        .record_end     (record_end),
        .dump_start     (dump_start),
        .dump_next      (dump_next),
        .dump_end       (dump_end),
        .data_in        (data_in),
        .busy           (busy)
    );

    always #5 comm_clock = ~comm_clock;

    // usart transmitter model and strobe monitor
    always @(negedge comm_clock) begin
        cyc++;
        if (!reset_n) last_tx = 8'h00;
        if (tx_start === 1'b1) begin
            if (tx_busy) viol_busy++;
            if (cyc - last_start_cyc < 2) viol_gap++;
            last_start_cyc = cyc;
            tx_q.push_back(tx_data);
            last_tx  = tx_data;
            busy_cnt = busy_len;
        end else begin
            if (reset_n && tx_data !== last_tx) viol_stab++;
            if (busy_cnt > 0) busy_cnt--;
        end
        tx_busy = (busy_cnt > 0);
        if (record_start === 1'b1)   n_rec++;
        if (record_trigger === 1'b1) n_trig++;
        if (dump_start === 1'b1)     n_dstart++;
        if (dump_next === 1'b1)      n_dnext++;
    end

    // snooper readout model
    always @(negedge comm_clock) begin
        if (dump_start === 1'b1) sn_ptr = 0;
        else if (dump_next === 1'b1) sn_ptr++;
        dump_end = (sn_ptr >= sn_valid);
        data_in  = (sn_ptr < sn_words.size()) ? sn_words[sn_ptr] : 32'h0;
    end

    function automatic byte_q_t dump_expect(input word_q_t w, input int n_valid, input int depth);
        byte_q_t q;
        string   hex = "0123456789ABCDEF";
        int      n = (n_valid < depth) ? n_valid : depth;
        for (int i = 0; i < n; i++) begin
            for (int d = 7; d >= 0; d--) q.push_back(hex[(w[i] >> (4 * d)) & 32'hF]);
            q.push_back(8'h20);
        end
        q.push_back(8'h0D);
        q.push_back(8'h0A);
        return q;
    endfunction

    function automatic string q2s(input byte_q_t q);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h", q[i])};
        return s;
    endfunction

    function automatic bit same_q(input byte_q_t a, input byte_q_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_mon();
        tx_q.delete();
        n_rec = 0; n_trig = 0; n_dstart = 0; n_dnext = 0;
        viol_busy = 0; viol_gap = 0; viol_stab = 0;
    endtask

    task automatic load_words(input int n_valid);
        sn_words.delete();
        for (int i = 0; i < 8; i++) sn_words.push_back($urandom);
        sn_valid = n_valid;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge comm_clock);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge comm_clock);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge comm_clock);
            n++;
        end
        repeat (3) @(negedge comm_clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge comm_clock);
        total++;
        if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        total++;
        if ({tx_start, record_start, record_trigger, dump_start, dump_next} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 00000",
                {tx_start, record_start, record_trigger, dump_start, dump_next});
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset_n = 1'b1;
        clear_mon();
        repeat (5) @(negedge comm_clock);
        total++;
        if (tx_q.size() != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_release_quiet: tx bytes %0d busy %b want 0 0", tx_q.size(), busy);
        end
    endtask

    task automatic test_record();
        byte_q_t exp;
        clear_mon();
        busy_len = 3;
        send_byte(8'h72);
        total++;
        if (record_start !== 1'b1) begin bad++; $display("FAIL rec_start_pulse: got %b want 1", record_start); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL rec_busy: got %b want 1", busy); end
        repeat (19) @(negedge comm_clock);
        record_end = 1'b1;
        wait_idle(300);
        record_end = 1'b0;
        exp = {8'h52};
        total++;
        if (n_rec != 1) begin bad++; $display("FAIL rec_start_count: got %0d want 1", n_rec); end
        total++;
        if (!same_q(tx_q, exp)) begin bad++; $display("FAIL rec_reply: got %s want %s", q2s(tx_q), q2s(exp)); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rec_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_trigger();
        byte_q_t exp;
        clear_mon();
        busy_len = 0;
        send_byte(8'h74);
        repeat (3) @(negedge comm_clock);
        total++;
        if (n_trig != 1 || busy !== 1'b0 || tx_q.size() != 0) begin
            bad++; $display("FAIL trig_idle: trig %0d busy %b tx %0d want 1 0 0", n_trig, busy, tx_q.size());
        end
        send_byte(8'h72);
        send_byte(8'h74);
        send_byte(8'h64);
        repeat (3) @(negedge comm_clock);
        total++;
        if (n_trig != 2 || n_dstart != 0 || busy !== 1'b1) begin
            bad++; $display("FAIL trig_rec_wait: trig %0d dstart %0d busy %b want 2 0 1", n_trig, n_dstart, busy);
        end
        record_end = 1'b1;
        wait_idle(100);
        record_end = 1'b0;
        exp = {8'h52};
        total++;
        if (!same_q(tx_q, exp)) begin bad++; $display("FAIL trig_reply: got %s want %s", q2s(tx_q), q2s(exp)); end
    endtask

    task automatic test_rec_priority();
        byte_q_t exp;
        clear_mon();
        send_byte(8'h72);
        repeat (5) @(negedge comm_clock);
        record_end = 1'b1;
        send_byte(8'h78);
        wait_idle(100);
        record_end = 1'b0;
        exp = {8'h52};
        total++;
        if (!same_q(tx_q, exp)) begin bad++; $display("FAIL rec_priority: got %s want %s", q2s(tx_q), q2s(exp)); end
    endtask

    task automatic test_unknown();
        byte_q_t    exp;
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            do b = 8'($urandom_range(255, 0));
            while (b == 8'h72 || b == 8'h74 || b == 8'h64 || b == 8'h78);
            clear_mon();
            busy_len = k;
            send_byte(b);
            wait_idle(100);
            exp = {8'h3F};
            total++;
            if (!same_q(tx_q, exp) || (n_rec + n_trig + n_dstart) != 0) begin
                bad++; $display("FAIL unknown_%02h: got %s strobes %0d want %s 0", b, q2s(tx_q),
                    n_rec + n_trig + n_dstart, q2s(exp));
            end
        end
    endtask

    task automatic test_dump_two();
        byte_q_t exp;
        string   s = "0000BEEF 12345678 ";
        load_words(2);
        sn_words[0] = 32'h0000BEEF;
        sn_words[1] = 32'h12345678;
        for (int i = 0; i < s.len(); i++) exp.push_back(s[i]);
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
        clear_mon();
        busy_len = 2;
        send_byte(8'h64);
        wait_idle(2000);
        total++;
        if (!same_q(tx_q, exp)) begin bad++; $display("FAIL dump_two_bytes: got %s want %s", q2s(tx_q), q2s(exp)); end
        total++;
        if (n_dnext != 2 || n_dstart != 1) begin
            bad++; $display("FAIL dump_two_strobes: next %0d start %0d want 2 1", n_dnext, n_dstart);
        end
    endtask

    task automatic test_dump_depth();
        byte_q_t exp;
        load_words(1000);
        exp = dump_expect(sn_words, 1000, DEPTH_TB);
        clear_mon();
        busy_len = 1;
        send_byte(8'h64);
        wait_idle(3000);
        total++;
        if (!same_q(tx_q, exp)) begin bad++; $display("FAIL dump_depth_bytes: got %s want %s", q2s(tx_q), q2s(exp)); end
        total++;
        if (n_dnext != DEPTH_TB) begin bad++; $display("FAIL dump_depth_next: got %0d want %0d", n_dnext, DEPTH_TB); end
    endtask

    task automatic test_abort();
        byte_q_t exp;
        int      n = 0;
        load_words(2);
        sn_words[0] = 32'h0000BEEF;
        exp = {8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        clear_mon();
        busy_len = 30;
        send_byte(8'h64);
        while (tx_q.size() < 3 && n < 1000) begin
            @(negedge comm_clock);
            n++;
        end
        total++;
        if (tx_q.size() != 3 || tx_busy !== 1'b1) begin
            bad++; $display("FAIL abort_setup: tx %0d busy %b want 3 1", tx_q.size(), tx_busy);
        end
        send_byte(8'h78);
        wait_idle(1000);
        total++;
        if (!same_q(tx_q, exp)) begin bad++; $display("FAIL abort_bytes: got %s want %s", q2s(tx_q), q2s(exp)); end
        total++;
        if (n_dnext != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_state: next %0d busy %b want 0 0", n_dnext, busy);
        end
    endtask

    task automatic test_slow_tx();
        byte_q_t exp;
        load_words(1);
        exp = dump_expect(sn_words, 1, DEPTH_TB);
        clear_mon();
        busy_len = 100;
        send_byte(8'h64);
        wait_idle(4000);
        total++;
        if (!same_q(tx_q, exp)) begin bad++; $display("FAIL slow_bytes: got %s want %s", q2s(tx_q), q2s(exp)); end
        total++;
        if (viol_busy != 0 || viol_gap != 0 || viol_stab != 0) begin
            bad++; $display("FAIL slow_handshake: busy %0d gap %0d stab %0d want 0 0 0", viol_busy, viol_gap, viol_stab);
        end
    endtask

    task automatic test_random();
        byte_q_t    exp;
        int         nv, k, nexp;
        logic [7:0] junk;
        for (int it = 0; it < 6; it++) begin
            nv = $urandom_range(6, 0);
            load_words(nv);
            exp  = dump_expect(sn_words, nv, DEPTH_TB);
            nexp = (nv < DEPTH_TB) ? nv : DEPTH_TB;
            clear_mon();
            busy_len = $urandom_range(4, 0);
            send_byte(8'h64);
            k = $urandom_range(40, 0);
            repeat (k) @(negedge comm_clock);
            if (busy === 1'b1) begin
                do junk = 8'($urandom_range(255, 0)); while (junk == 8'h78);
                send_byte(junk);
            end
            wait_idle(3000);
            total++;
            if (!same_q(tx_q, exp)) begin bad++; $display("FAIL rand%0d_bytes: got %s want %s", it, q2s(tx_q), q2s(exp)); end
            total++;
            if (n_dnext != nexp || n_dstart != 1) begin
                bad++; $display("FAIL rand%0d_strobes: next %0d start %0d want %0d 1", it, n_dnext, n_dstart, nexp);
            end
            total++;
            if (viol_busy != 0 || viol_gap != 0 || viol_stab != 0) begin
                bad++; $display("FAIL rand%0d_handshake: busy %0d gap %0d stab %0d want 0 0 0",
                    it, viol_busy, viol_gap, viol_stab);
            end
        end
    endtask

    task automatic test_reset_mid_dump();
        int      n = 0, snap_tx, snap_str;
        byte_q_t exp;
        load_words(3);
        clear_mon();
        busy_len = 10;
        send_byte(8'h64);
        while (tx_q.size() < 5 && n < 1000) begin
            @(negedge comm_clock);
            n++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || tx_data !== 8'h00) begin
            bad++; $display("FAIL rst_mid_out: busy %b tx_data %h want 0 00", busy, tx_data);
        end
        total++;
        if ({tx_start, record_start, record_trigger, dump_start, dump_next} !== 5'b0) begin
            bad++; $display("FAIL rst_mid_strobes: got %b want 00000",
                {tx_start, record_start, record_trigger, dump_start, dump_next});
        end
        snap_tx  = tx_q.size();
        snap_str = n_rec + n_trig + n_dstart + n_dnext;
        repeat (3) @(negedge comm_clock);
        reset_n = 1'b1;
        repeat (60) @(negedge comm_clock);
        total++;
        if (tx_q.size() != snap_tx || (n_rec + n_trig + n_dstart + n_dnext) != snap_str || busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_quiet: tx %0d strobes %0d busy %b want %0d %0d 0",
                tx_q.size(), n_rec + n_trig + n_dstart + n_dnext, busy, snap_tx, snap_str);
        end
        load_words(1);
        exp = dump_expect(sn_words, 1, DEPTH_TB);
        clear_mon();
        busy_len = 2;
        send_byte(8'h64);
        wait_idle(2000);
        total++;
        if (!same_q(tx_q, exp)) begin bad++; $display("FAIL rst_recover: got %s want %s", q2s(tx_q), q2s(exp)); end
    endtask

    initial begin
        test_reset();
        test_record();
        test_trigger();
        test_rec_priority();
        test_unknown();
        test_dump_two();
        test_dump_depth();
        test_abort();
        test_slow_tx();
        test_random();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time bound reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
